// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - execute, data-memory and writeback signals of the load/store unit
interface load_store_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_fault;

  // Unit-side view: drives the memory port, the ready and the writeback result.
  modport master (
    input  in_valid, in_store, in_funct3, in_addr, in_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output out_valid, out_data, out_fault
  );

  // Environment view: execute stage, data memory and writeback.
  modport slave (
    output in_valid, in_store, in_funct3, in_addr, in_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  out_valid, out_data, out_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store stage with lane steering and load extension
module load_store_unit (
  input  logic              CLK,
  input  logic              RST_X,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        op_store_q, op_store_d;
  logic [2:0]  op_funct3_q, op_funct3_d;
  logic [1:0]  op_off_q, op_off_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_fault_q, out_fault_d;

  logic        accept;
  logic        in_fault;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_shifted;
  logic [31:0] ld_value;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign accept        = bus.in_valid && (state_q == S_IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_fault = out_fault_q;

  // Illegal width codes and misaligned halfword/word addresses fault before any memory access.
  always_comb begin
    in_fault = 1'b0;
    if (bus.in_store) begin
      if (bus.in_funct3 > 3'b010) in_fault = 1'b1;
    end else begin
      if (bus.in_funct3 == 3'b011 || bus.in_funct3 == 3'b110 || bus.in_funct3 == 3'b111)
        in_fault = 1'b1;
    end
    if (bus.in_funct3[1:0] == 2'b01 && bus.in_addr[0]) in_fault = 1'b1;
    if (bus.in_funct3[1:0] == 2'b10 && bus.in_addr[1:0] != 2'b00) in_fault = 1'b1;
  end

  // Store data is replicated across lanes so the enables alone pick the bytes; loads read the whole word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = bus.in_wdata;
    if (bus.in_store) begin
      case (bus.in_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << bus.in_addr[1:0];
          st_wdata = {4{bus.in_wdata[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << bus.in_addr[1:0];
          st_wdata = {2{bus.in_wdata[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = bus.in_wdata;
        end
      endcase
    end else begin
      st_wdata = 32'd0;
    end
  end

  // Move the addressed lane to bit 0 and extend it according to the captured width code.
  always_comb begin
    ld_shifted = bus.mem_rdata >> {op_off_q, 3'b000};
    case (op_funct3_q)
      3'b000:  ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b010:  ld_value = bus.mem_rdata;
      3'b100:  ld_value = {24'd0, ld_shifted[7:0]};
      3'b101:  ld_value = {16'd0, ld_shifted[15:0]};
      default: ld_value = 32'd0;
    endcase
  end

  // Next state plus next values of every registered output; outputs default to 0 each cycle.
  always_comb begin
    state_d     = state_q;
    op_store_d  = op_store_q;
    op_funct3_d = op_funct3_q;
    op_off_d    = op_off_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'd0;
    mem_be_d    = 4'd0;
    mem_wdata_d = 32'd0;
    out_valid_d = 1'b0;
    out_data_d  = 32'd0;
    out_fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_store_d  = bus.in_store;
          op_funct3_d = bus.in_funct3;
          op_off_d    = bus.in_addr[1:0];
          if (in_fault) begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
            out_fault_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.in_store;
            mem_addr_d  = {bus.in_addr[31:2], 2'b00};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          if (op_store_q) begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_addr_d  = mem_addr_q;
          mem_be_d    = mem_be_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d     = S_RESP;
          out_valid_d = 1'b1;
          out_data_d  = ld_value;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, captured operation and registered outputs.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= S_IDLE;
      op_store_q  <= 1'b0;
      op_funct3_q <= 3'd0;
      op_off_q    <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_store_q  <= op_store_d;
      op_funct3_q <= op_funct3_d;
      op_off_q    <= op_off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_fault_q <= out_fault_d;
    end
  end

endmodule
